// File: rtl/eth_rx_drainer.sv
// eth_rx_drainer: drains received packets from an Ethernet controller's RX buffer
// over a 32-bit MMIO port and presents them as a valid/ready word stream.
//
// state  | meaning
// -------+-------------------------------------------------------------
// INIT   | write 1 to the RX interrupt enable register
// IDLE   | wait for the controller RX-pending interrupt
// POLL   | read the RX status register
// POLL_W | status returns: 1 -> fetch size, otherwise back to IDLE
// SIZE   | read the received packet size register
// SIZE_W | size returns: bad size -> drop, good size -> start reading
// RD     | read the next 4-byte word of the RX buffer
// RD_W   | word returns: load the stream output registers
// SEND   | present the word until the consumer accepts it
// CLEAR  | write 1 to the RX status register to release the buffer
module eth_rx_drainer #(
   parameter int buf_size_p       = 2048,
   parameter int data_width_p     = 32,
   parameter int reg_addr_width_p = 16
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   output logic [reg_addr_width_p-1:0] addr_o,
   output logic                        write_en_o,
   output logic                        read_en_o,
   output logic [1:0]                  op_size_o,
   output logic [data_width_p-1:0]     write_data_o,
   input  logic [data_width_p-1:0]     read_data_i,
   input  logic                        rx_interrupt_pending_i,
   output logic [data_width_p-1:0]     data_o,
   output logic [3:0]                  keep_o,
   output logic                        last_o,
   output logic                        v_o,
   input  logic                        ready_i,
   output logic [15:0]                 pkt_count_o,
   output logic [15:0]                 drop_count_o
);

   typedef enum logic [3:0] {
      INIT, IDLE, POLL, POLL_W, SIZE, SIZE_W, RD, RD_W, SEND, CLEAR
   } state_e;

   localparam logic [reg_addr_width_p-1:0] ADDR_RX_BUF  = reg_addr_width_p'(16'h0000);
   localparam logic [reg_addr_width_p-1:0] ADDR_RX_SIZE = reg_addr_width_p'(16'h1004);
   localparam logic [reg_addr_width_p-1:0] ADDR_RX_STAT = reg_addr_width_p'(16'h1010);
   localparam logic [reg_addr_width_p-1:0] ADDR_RX_IE   = reg_addr_width_p'(16'h1014);
   localparam logic [31:0]                 BUF_SIZE     = 32'(buf_size_p);

   state_e                    state_q, state_d;
   logic [31:0]               size_q, size_d;
   logic [31:0]               offset_q, offset_d;
   logic [data_width_p-1:0]   data_q, data_d;
   logic [3:0]                keep_q, keep_d;
   logic                      last_q, last_d;
   logic                      delivered_q, delivered_d;
   logic [15:0]               pkt_cnt_q, pkt_cnt_d;
   logic [15:0]               drop_cnt_q, drop_cnt_d;

   logic [31:0]               remaining;
   logic [32:0]               offset_plus4;
   logic [3:0]                keep_next;
   logic                      last_next;
   logic                      size_bad;

   // Byte accounting for the word currently being fetched.
   always_comb begin
      remaining    = size_q - offset_q;
      offset_plus4 = {1'b0, offset_q} + 33'd4;
      last_next    = offset_plus4 >= {1'b0, size_q};
      keep_next    = 4'b1111;
      if (remaining < 32'd4) begin
         unique case (remaining[1:0])
            2'd1:    keep_next = 4'b0001;
            2'd2:    keep_next = 4'b0011;
            2'd3:    keep_next = 4'b0111;
            default: keep_next = 4'b0000;
         endcase
      end
      size_bad = (read_data_i[31:0] == 32'd0) || (read_data_i[31:0] > BUF_SIZE);
   end

   // MMIO access decode; the bus stays quiet while reset is held so no
   // INIT write leaks out before release.
   always_comb begin
      addr_o       = '0;
      write_en_o   = 1'b0;
      read_en_o    = 1'b0;
      write_data_o = '0;
      if (!reset_i) begin
         unique case (state_q)
            INIT: begin
               write_en_o   = 1'b1;
               addr_o       = ADDR_RX_IE;
               write_data_o = data_width_p'(1);
            end
            POLL: begin
               read_en_o = 1'b1;
               addr_o    = ADDR_RX_STAT;
            end
            SIZE: begin
               read_en_o = 1'b1;
               addr_o    = ADDR_RX_SIZE;
            end
            RD: begin
               read_en_o = 1'b1;
               addr_o    = ADDR_RX_BUF | offset_q[reg_addr_width_p-1:0];
            end
            CLEAR: begin
               write_en_o   = 1'b1;
               addr_o       = ADDR_RX_STAT;
               write_data_o = data_width_p'(1);
            end
            default: ;
         endcase
      end
   end

   // Sequencer next-state, packet bookkeeping and stream register loads.
   always_comb begin
      state_d     = state_q;
      size_d      = size_q;
      offset_d    = offset_q;
      data_d      = data_q;
      keep_d      = keep_q;
      last_d      = last_q;
      delivered_d = delivered_q;
      pkt_cnt_d   = pkt_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      unique case (state_q)
         INIT: state_d = IDLE;
         IDLE: begin
            if (rx_interrupt_pending_i) state_d = POLL;
         end
         POLL: state_d = POLL_W;
         POLL_W: begin
            if (read_data_i == data_width_p'(1)) state_d = SIZE;
            else                                 state_d = IDLE;
         end
         SIZE: state_d = SIZE_W;
         SIZE_W: begin
            size_d   = read_data_i[31:0];
            offset_d = 32'd0;
            if (size_bad) begin
               drop_cnt_d  = drop_cnt_q + 16'd1;
               delivered_d = 1'b0;
               state_d     = CLEAR;
            end else begin
               delivered_d = 1'b1;
               state_d     = RD;
            end
         end
         RD: state_d = RD_W;
         RD_W: begin
            data_d  = read_data_i;
            keep_d  = keep_next;
            last_d  = last_next;
            state_d = SEND;
         end
         SEND: begin
            if (ready_i) begin
               offset_d = offset_plus4[31:0];
               state_d  = last_q ? CLEAR : RD;
            end
         end
         CLEAR: begin
            if (delivered_q) pkt_cnt_d = pkt_cnt_q + 16'd1;
            delivered_d = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = INIT;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= INIT;
         size_q      <= '0;
         offset_q    <= '0;
         data_q      <= '0;
         keep_q      <= '0;
         last_q      <= 1'b0;
         delivered_q <= 1'b0;
         pkt_cnt_q   <= '0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         size_q      <= size_d;
         offset_q    <= offset_d;
         data_q      <= data_d;
         keep_q      <= keep_d;
         last_q      <= last_d;
         delivered_q <= delivered_d;
         pkt_cnt_q   <= pkt_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign op_size_o    = 2'b10;
   assign v_o          = (state_q == SEND);
   assign data_o       = data_q;
   assign keep_o       = keep_q;
   assign last_o       = last_q;
   assign pkt_count_o  = pkt_cnt_q;
   assign drop_count_o = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_drainer.sv
// Directed bench for eth_rx_drainer with a small MMIO controller model.
module tb_eth_rx_drainer;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic [15:0] addr_o;
   logic        write_en_o, read_en_o;
   logic [1:0]  op_size_o;
   logic [31:0] write_data_o, read_data_i;
   logic        rx_interrupt_pending_i;
   logic [31:0] data_o;
   logic [3:0]  keep_o;
   logic        last_o, v_o, ready_i;
   logic [15:0] pkt_count_o, drop_count_o;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_i = ~clk_i;

   eth_rx_drainer dut (
      .clk_i                  (clk_i),
      .reset_i                (reset_i),
      .addr_o                 (addr_o),
      .write_en_o             (write_en_o),
      .read_en_o              (read_en_o),
      .op_size_o              (op_size_o),
      .write_data_o           (write_data_o),
      .read_data_i            (read_data_i),
      .rx_interrupt_pending_i (rx_interrupt_pending_i),
      .data_o                 (data_o),
      .keep_o                 (keep_o),
      .last_o                 (last_o),
      .v_o                    (v_o),
      .ready_i                (ready_i),
      .pkt_count_o            (pkt_count_o),
      .drop_count_o           (drop_count_o)
   );

   // controller model
   logic [31:0] pend_val, size_val;

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      return 32'hC0DE_0000 | {16'h0000, a};
   endfunction

   always @(posedge clk_i) begin
      if (read_en_o) begin
         case (addr_o)
            16'h1010: read_data_i <= pend_val;
            16'h1004: read_data_i <= size_val;
            default:  read_data_i <= mem_word(addr_o);
         endcase
      end else begin
         read_data_i <= 32'hDEAD_BEEF;
      end
   end

   // bus / stream monitor
   int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0, vo_cnt = 0;
   logic [15:0] last_wr_addr = '0, last_rd_addr = '0;
   logic [31:0] last_wr_data = '0;
   logic [31:0] w_data[$];
   logic [3:0]  w_keep[$];
   logic        w_last[$];

   always @(negedge clk_i) begin
      if (write_en_o && read_en_o) both_cnt++;
      if (write_en_o) begin
         wr_cnt++;
         last_wr_addr = addr_o;
         last_wr_data = write_data_o;
      end
      if (read_en_o) begin
         rd_cnt++;
         last_rd_addr = addr_o;
      end
      if (v_o) vo_cnt++;
      if (v_o && ready_i) begin
         w_data.push_back(data_o);
         w_keep.push_back(keep_o);
         w_last.push_back(last_o);
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_logs();
      w_data.delete();
      w_keep.delete();
      w_last.delete();
      vo_cnt = 0;
   endtask

   task automatic pulse_irq();
      rx_interrupt_pending_i = 1'b1;
      tick();
      rx_interrupt_pending_i = 1'b0;
   endtask

   task automatic wait_pkt(input string tag, input logic [15:0] target);
      for (int i = 0; i < 3000 && pkt_count_o != target; i++) tick();
      check({tag, "_pkt_count"}, pkt_count_o, target);
   endtask

   task automatic wait_wr(input string tag, input int target);
      for (int i = 0; i < 500 && wr_cnt != target; i++) tick();
      check({tag, "_wr_cnt"}, wr_cnt, target);
   endtask

   task automatic check_words(input string tag, input int size);
      int n;
      int rem;
      logic [3:0] k;
      n = (size + 3) / 4;
      check({tag, "_nwords"}, w_data.size(), n);
      if (w_data.size() == n) begin
         for (int i = 0; i < n; i++) begin
            rem = size - 4 * i;
            k = (rem >= 4) ? 4'b1111 : 4'((1 << rem) - 1);
            check($sformatf("%s_data%0d", tag, i), w_data[i], mem_word(16'(4 * i)));
            check($sformatf("%s_keep%0d", tag, i), w_keep[i], k);
            check($sformatf("%s_last%0d", tag, i), w_last[i], (i == n - 1));
         end
      end
   endtask

   initial begin
      int wr0, rd0, strobes0, unstable;
      logic [31:0] d0;
      logic [3:0]  k0;
      logic        l0;

      reset_i = 1'b1;
      rx_interrupt_pending_i = 1'b0;
      ready_i = 1'b1;
      pend_val = 32'd1;
      size_val = 32'd0;
      repeat (3) tick();
      check("rst_write_en", write_en_o, 0);
      check("rst_read_en", read_en_o, 0);
      check("rst_addr", addr_o, 0);
      check("rst_v", v_o, 0);
      check("rst_pkt", pkt_count_o, 0);
      check("rst_drop", drop_count_o, 0);
      check("rst_wr_seen", wr_cnt, 0);

      // init sequence
      reset_i = 1'b0;
      repeat (6) tick();
      check("init_wr_cnt", wr_cnt, 1);
      check("init_wr_addr", last_wr_addr, 16'h1014);
      check("init_wr_data", last_wr_data, 1);
      check("init_rd_cnt", rd_cnt, 0);
      check("op_size", op_size_o, 2'b10);

      // 64-byte packet
      clear_logs();
      wr0 = wr_cnt; rd0 = rd_cnt;
      size_val = 32'd64;
      pulse_irq();
      wait_pkt("p64", 16'd1);
      tick();
      check_words("p64", 64);
      check("p64_wr_cnt", wr_cnt - wr0, 1);
      check("p64_wr_addr", last_wr_addr, 16'h1010);
      check("p64_wr_data", last_wr_data, 1);
      check("p64_rd_cnt", rd_cnt - rd0, 18);
      check("p64_last_rd", last_rd_addr, 16'h003C);
      check("p64_drop", drop_count_o, 0);

      // 66-byte packet, partial tail word
      clear_logs();
      rd0 = rd_cnt;
      size_val = 32'd66;
      pulse_irq();
      wait_pkt("p66", 16'd2);
      tick();
      check_words("p66", 66);
      check("p66_rd_cnt", rd_cnt - rd0, 19);
      check("p66_last_rd", last_rd_addr, 16'h0040);

      // size 0 and oversize packets are dropped
      clear_logs();
      wr0 = wr_cnt;
      size_val = 32'd0;
      pulse_irq();
      wait_wr("drop0", wr0 + 1);
      check("drop0_wr_addr", last_wr_addr, 16'h1010);
      check("drop0_drop", drop_count_o, 1);
      size_val = 32'd4096;
      pulse_irq();
      wait_wr("drop4k", wr0 + 2);
      tick();
      check("drop4k_wr_addr", last_wr_addr, 16'h1010);
      check("drop4k_wr_data", last_wr_data, 1);
      check("drop_count", drop_count_o, 2);
      check("drop_pkt", pkt_count_o, 2);
      check("drop_no_v", vo_cnt, 0);

      // exactly buf_size bytes is accepted
      clear_logs();
      size_val = 32'd2048;
      pulse_irq();
      wait_pkt("p2048", 16'd3);
      check("p2048_nwords", w_data.size(), 512);
      check("p2048_drop", drop_count_o, 2);

      // stall on word 3 of a 20-byte packet
      clear_logs();
      size_val = 32'd20;
      pulse_irq();
      for (int i = 0; i < 500 && w_data.size() < 2; i++) tick();
      ready_i = 1'b0;
      for (int i = 0; i < 50 && !v_o; i++) tick();
      check("stall_v_up", v_o, 1);
      d0 = data_o; k0 = keep_o; l0 = last_o;
      strobes0 = rd_cnt + wr_cnt;
      unstable = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (!v_o || data_o !== d0 || keep_o !== k0 || last_o !== l0) unstable++;
      end
      check("stall_stable", unstable, 0);
      check("stall_strobes", rd_cnt + wr_cnt - strobes0, 0);
      check("stall_word3", d0, mem_word(16'h0008));
      ready_i = 1'b1;
      wait_pkt("p20", 16'd4);
      tick();
      check_words("p20", 20);

      // poll returns 0: back to idle without size read or write
      pend_val = 32'd0;
      wr0 = wr_cnt; rd0 = rd_cnt;
      pulse_irq();
      repeat (20) tick();
      check("poll0_rd_cnt", rd_cnt - rd0, 1);
      check("poll0_rd_addr", last_rd_addr, 16'h1010);
      check("poll0_wr_cnt", wr_cnt - wr0, 0);
      check("poll0_pkt", pkt_count_o, 4);
      pend_val = 32'd1;

      // reset mid-packet abandons without clear write
      size_val = 32'd64;
      ready_i = 1'b0;
      pulse_irq();
      for (int i = 0; i < 100 && !v_o; i++) tick();
      check("midrst_v_up", v_o, 1);
      reset_i = 1'b1;
      tick();
      check("midrst_v", v_o, 0);
      check("midrst_wen", write_en_o, 0);
      check("midrst_ren", read_en_o, 0);
      check("midrst_data", data_o, 0);
      check("midrst_keep", keep_o, 0);
      check("midrst_last", last_o, 0);
      check("midrst_pkt", pkt_count_o, 0);
      check("midrst_drop", drop_count_o, 0);
      wr0 = wr_cnt;
      tick();
      reset_i = 1'b0;
      ready_i = 1'b1;
      repeat (6) tick();
      check("midrst_wr_cnt", wr_cnt - wr0, 1);
      check("midrst_wr_addr", last_wr_addr, 16'h1014);
      check("both_strobes", both_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
